// File: rtl/adsr_voice_sequencer.sv
// -----------------------------------------------------------------------------
// adsr_voice_sequencer
//
// Sequences the shared ADSR envelope datapath across all synth voices. Once
// per audio sample (sample_tick) it sweeps voice_index over 0..NUM_VOICES-1,
// advancing only on phase-1 edges so each voice is held for a full
// phase-0/phase-1 pair, and parks on PARK_ADDR between sweeps. Between sweeps
// it owns port A of the ADSR parameter RAM and applies key on/off events by
// read-modify-write of bit 0, leaving bits 37:1 untouched.
//
// Optional feature macro: ADSR_SEQ_OVERRUN_DET_EN
//   defined   : a tick during a sweep, or while a tick is already pending,
//               sets the sticky 'overrun' flag (cleared by overrun_clr;
//               a set on the same clock as a clear wins).
//   undefined : 'overrun' stays 0 and late ticks are dropped silently.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset (shared with the
//                     datapath so the phase register lines up with it)
//   sample_tick       one-clock pulse starting a sweep
//   ev_valid/ev_ready key-event handshake; ev_voice target, ev_on key state
//   voice_index       voice presented to the datapath
//   adsr_addr/din     port A address / write data
//   adsr_write_en     port A write strobe (one clock per RMW)
//   adsr_dout         port A read data (registered RAM output)
//   mix_valid         datapath sample valid this clock, for voice mix_voice
//   overrun           sticky late-tick flag; overrun_clr clears it
// -----------------------------------------------------------------------------
module adsr_voice_sequencer #(
  parameter int         NUM_VOICES = 32,
  parameter logic [7:0] PARK_ADDR  = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_tick,
  input  logic        ev_valid,
  output logic        ev_ready,
  input  logic [7:0]  ev_voice,
  input  logic        ev_on,
  output logic [7:0]  voice_index,
  output logic [7:0]  adsr_addr,
  output logic [37:0] adsr_din,
  output logic        adsr_write_en,
  input  logic [37:0] adsr_dout,
  output logic        mix_valid,
  output logic [7:0]  mix_voice,
  output logic        overrun,
  input  logic        overrun_clr
);

  localparam logic [7:0] LP_NUM_VOICES = 8'(NUM_VOICES);
  localparam logic [7:0] LP_LAST_VOICE = 8'(NUM_VOICES - 1);

  typedef enum logic {
    SW_IDLE,
    SW_SWEEP
  } sweep_state_t;

  typedef enum logic [2:0] {
    RMW_IDLE,
    RMW_RD,
    RMW_WAIT,
    RMW_CAP,
    RMW_WR
  } rmw_state_t;

  sweep_state_t r_sw_state;
  sweep_state_t w_sw_next;
  rmw_state_t   r_rmw_state;
  rmw_state_t   w_rmw_next;

  logic        r_phase;
  logic        r_pending;
  logic        r_rdy;
  logic [7:0]  r_voice_index;
  logic [7:0]  r_addr;
  logic [37:0] r_din;
  logic        r_we;
  logic        r_on;
  logic        r_mix_valid;
  logic [7:0]  r_mix_voice;
  logic        r_overrun;

  logic        w_tick_req;
  logic        w_start;
  logic        w_pending_next;
  logic [7:0]  w_voice_next;
  logic        w_accept;
  logic        w_in_range;
  logic        w_rdy_next;
  logic        w_mix_fire;
  logic        w_overrun_set;

  // A sweep may only begin on a phase-1 edge with port A quiet, so a tick that
  // lands mid-RMW or on a phase-0 edge is carried by r_pending until then.
  assign w_tick_req = sample_tick | r_pending;
  assign w_start    = r_phase & (r_sw_state == SW_IDLE) &
                      (r_rmw_state == RMW_IDLE) & w_tick_req;

  assign w_accept   = ev_valid & ev_ready;
  assign w_in_range = (ev_voice < LP_NUM_VOICES);

  // The accept clock itself drops readiness, so an out-of-range event (which
  // leaves the RMW FSM idle) still costs exactly one clock of ev_ready.
  assign w_rdy_next = (w_rmw_next == RMW_IDLE) & (w_sw_next == SW_IDLE) &
                      ~w_pending_next & ~w_accept;

  // The swept voice's sample is ready on the clock after its phase-1 clock.
  assign w_mix_fire = r_phase & (r_sw_state == SW_SWEEP);

`ifdef ADSR_SEQ_OVERRUN_DET_EN
  assign w_overrun_set = sample_tick & ((r_sw_state == SW_SWEEP) | r_pending);
`else
  // Never set, so the flag register below holds its reset value of 0.
  assign w_overrun_set = 1'b0;
`endif

  // Sweep FSM next-state and next voice_index.
  always_comb begin
    w_sw_next    = r_sw_state;
    w_voice_next = r_voice_index;
    case (r_sw_state)
      SW_IDLE: begin
        if (w_start) begin
          w_sw_next    = SW_SWEEP;
          w_voice_next = 8'd0;
        end else begin
          w_sw_next    = SW_IDLE;
          w_voice_next = PARK_ADDR;
        end
      end
      SW_SWEEP: begin
        if (r_phase) begin
          if (r_voice_index == LP_LAST_VOICE) begin
            w_sw_next    = SW_IDLE;
            w_voice_next = PARK_ADDR;
          end else begin
            w_sw_next    = SW_SWEEP;
            w_voice_next = r_voice_index + 8'd1;
          end
        end else begin
          w_sw_next    = SW_SWEEP;
          w_voice_next = r_voice_index;
        end
      end
      default: begin
        w_sw_next    = SW_IDLE;
        w_voice_next = PARK_ADDR;
      end
    endcase
  end

  // Pending-tick latch: cleared when the sweep starts, ignored during a sweep.
  always_comb begin
    w_pending_next = r_pending;
    if (w_start) begin
      w_pending_next = 1'b0;
    end else if (sample_tick && (r_sw_state == SW_IDLE)) begin
      w_pending_next = 1'b1;
    end else begin
      w_pending_next = r_pending;
    end
  end

  // Key RMW FSM next-state: read, wait for the registered RAM, capture, write.
  always_comb begin
    w_rmw_next = r_rmw_state;
    case (r_rmw_state)
      RMW_IDLE: begin
        if (w_accept && w_in_range) begin
          w_rmw_next = RMW_RD;
        end else begin
          w_rmw_next = RMW_IDLE;
        end
      end
      RMW_RD:   w_rmw_next = RMW_WAIT;
      RMW_WAIT: w_rmw_next = RMW_CAP;
      RMW_CAP:  w_rmw_next = RMW_WR;
      RMW_WR:   w_rmw_next = RMW_IDLE;
      default:  w_rmw_next = RMW_IDLE;
    endcase
  end

  // State registers: phase toggle, both FSMs, pending tick, readiness.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase       <= 1'b0;
      r_sw_state    <= SW_IDLE;
      r_rmw_state   <= RMW_IDLE;
      r_pending     <= 1'b0;
      r_voice_index <= PARK_ADDR;
      r_rdy         <= 1'b0;
    end else begin
      r_phase       <= ~r_phase;
      r_sw_state    <= w_sw_next;
      r_rmw_state   <= w_rmw_next;
      r_pending     <= w_pending_next;
      r_voice_index <= w_voice_next;
      r_rdy         <= w_rdy_next;
    end
  end

  // Port A address/data, write strobe and mixer flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr      <= 8'd0;
      r_on        <= 1'b0;
      r_din       <= 38'd0;
      r_we        <= 1'b0;
      r_mix_valid <= 1'b0;
      r_mix_voice <= 8'd0;
    end else begin
      if (w_accept && w_in_range) begin
        r_addr <= ev_voice;
        r_on   <= ev_on;
      end
      // Only the key bit is replaced; envelope/state bits pass through.
      if (r_rmw_state == RMW_CAP) begin
        r_din <= (adsr_dout & ~38'd1) | {37'd0, r_on};
      end
      r_we        <= (r_rmw_state == RMW_CAP);
      r_mix_valid <= w_mix_fire;
      if (w_mix_fire) begin
        r_mix_voice <= r_voice_index;
      end
    end
  end

  // Sticky overrun flag; a set on the same clock as a clear takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (w_overrun_set) begin
      r_overrun <= 1'b1;
    end else if (overrun_clr) begin
      r_overrun <= 1'b0;
    end
  end

  assign ev_ready      = r_rdy & ~sample_tick;
  assign voice_index   = r_voice_index;
  assign adsr_addr     = r_addr;
  assign adsr_din      = r_din;
  assign adsr_write_en = r_we;
  assign mix_valid     = r_mix_valid;
  assign mix_voice     = r_mix_voice;
  assign overrun       = r_overrun;

endmodule

// File: doc/adsr_voice_sequencer.md
# adsr_voice_sequencer

Controller that sequences the shared ADSR envelope datapath across all synth voices. Once per audio sample it sweeps `voice_index` over voices 0..NUM_VOICES-1 at the ADSR's fixed two-clock cadence, and parks the datapath on an unused slot between sweeps. Between sweeps it owns the ADSR parameter RAM's port A and applies note-on/off key-state updates from the voice controller by read-modify-write. It flags each enveloped sample to the downstream mixer.

## Interface
Parameters:
- `NUM_VOICES`, 32: voices per sweep; 1..255.
- `PARK_ADDR`, 8'hFF: address the datapath idles on; must be ≥ NUM_VOICES and never written.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset; one clock; reset is asynchronous and active-high. Must be the same reset as the ADSR datapath so its phase aligns.
- `sample_tick` in 1: one-clock pulse that starts a sweep.
- `ev_valid` in 1: key event pending.
- `ev_ready` out 1: event accepted on `ev_valid & ev_ready`.
- `ev_voice` in 8: target voice.
- `ev_on` in 1: 1 = key down, 0 = key up.
- `voice_index` out 8: to the datapath `voice_index`.
- `adsr_addr` out 8: port A address.
- `adsr_din` out 38: port A write data.
- `adsr_write_en` out 1: port A write strobe.
- `adsr_dout` in 38: port A read data.
- `mix_valid` out 1: datapath `output_sample` is valid this clock.
- `mix_voice` out 8: voice that the sample belongs to.
- `overrun` out 1: sticky; see Configuration.
- `overrun_clr` in 1: clears `overrun`.

## Operation
- `phase` register: reset 0, toggles every clock. It mirrors the datapath's two-clock cycle.
- `voice_index` changes only on an edge where `phase` = 1. The new value is therefore stable across a full phase-0/phase-1 pair.
- Sweep FSM:
  - IDLE: `voice_index` = PARK_ADDR.
  - A tick, or a latched pending tick, moves the FSM to SWEEP on the next phase-1 edge with `voice_index` = 0.
  - SWEEP: `voice_index` increments every phase-1 edge.
  - After voice NUM_VOICES-1 the FSM returns to IDLE with `voice_index` = PARK_ADDR.
- Tick arriving while an RMW is in flight: latch it as `tick_pending`. The sweep starts on the first phase-1 edge after the RMW completes.
- Tick arriving during SWEEP: ignored, and handled per Configuration.
- Key RMW FSM (IDLE→RD→WAIT→CAP→WR→IDLE):
  - `ev_ready` = 1 only when both FSMs are IDLE, no tick is pending, and `sample_tick` = 0.
  - On accept, `ev_voice` and `ev_on` are registered and `adsr_addr` ← `ev_voice`.
  - RD: address is presented.
  - WAIT: the RAM registers it.
  - CAP: `adsr_dout` is captured.
  - WR: `adsr_din` = {captured[37:1], ev_on}, `adsr_write_en` = 1 for exactly one clock.
  - Bits 37:1 (envelope and state) are never altered by the controller.
- An event with `ev_voice` ≥ NUM_VOICES is accepted and dropped, with no RAM access and `ev_ready` returning after one clock.
- `mix_valid` pulses for one clock, on the clock after each swept voice's phase-1 clock, with `mix_voice` = that voice. It never pulses for PARK_ADDR.
- Reset mid-sweep or mid-RMW: all FSMs go to IDLE and the pending tick is dropped. A partial RMW never writes.

## Timing
- Reset values:
  - `voice_index` = PARK_ADDR, `adsr_addr` = 0, `adsr_din` = 0.
  - `adsr_write_en` = 0, `ev_ready` = 0 (1 from the first clock after reset).
  - `mix_valid` = 0, `mix_voice` = 0, `overrun` = 0.
- Sweep length: 2·NUM_VOICES clocks. Worst-case start latency from tick: 1 clock (phase alignment) plus 5 clocks (RMW).
- RMW: write strobe occurs 4 clocks after the accept edge. The next accept is possible 5 clocks after accept.
- Sample period must exceed 2·NUM_VOICES + 6 clocks.

## Configuration
- `ADSR_SEQ_OVERRUN_DET_EN` defined:
  - A `sample_tick` during SWEEP or while `tick_pending` is set sets `overrun`.
  - `overrun` stays set until `overrun_clr` is 1. If set and clear land on the same clock, set wins.
- Macro undefined:
  - `overrun` is tied 0 and `overrun_clr` is ignored.
  - Late ticks are dropped silently.

## Test plan
- Reset with a tick 3 clocks later, NUM_VOICES=4 → `voice_index` sequence PARK,0,0,1,1,2,2,3,3,PARK, changing only on phase-1 edges. `mix_valid` pulses 4 times with `mix_voice` 0,1,2,3.
- Event voice=5, on=1 while IDLE, port A returns 0x3FFFFFFFFE → one write of 0x3FFFFFFFFF to addr 5, 4 clocks after accept.
- Same voice with on=0 and read data 0x0000000023 → write 0x0000000022. No other bit changes.
- Tick 2 clocks after event accept → `ev_ready` low, no write collision. Sweep starts after WR; voice 0 is presented within 6 clocks of the tick.
- With the macro defined, a second tick mid-sweep → `overrun` = 1, sweep sequence unchanged. `overrun_clr` → 0. Without the macro → `overrun` stays 0.
- Assert `reset` mid-RMW in the CAP state → `adsr_write_en` never asserts, `voice_index` = PARK_ADDR immediately, and the next tick sweeps normally.
